// File: rtl/xgmii_tx_arbiter.sv
// Two-source XGMII TX arbiter: round-robin grant at frame boundaries, forced idle gap,
// watchdog/underrun abort with an error column, and per-source frame/abort counters.
module xgmii_tx_arbiter #(
    parameter int IFG_WORDS       = 2,
    parameter int MAX_FRAME_WORDS = 1200
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        enable,
    input  logic        s0_valid,
    input  logic [63:0] s0_txd,
    input  logic [7:0]  s0_txc,
    input  logic        s0_last,
    output logic        s0_ready,
    input  logic        s1_valid,
    input  logic [63:0] s1_txd,
    input  logic [7:0]  s1_txc,
    input  logic        s1_last,
    output logic        s1_ready,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic        active_src,
    output logic        busy,
    output logic [31:0] frames0,
    output logic [31:0] frames1,
    output logic [15:0] abort_cnt
);

    localparam int CNT_RAW = $clog2(MAX_FRAME_WORDS + 1);
    localparam int CNT_W   = (CNT_RAW < 11) ? 11 : CNT_RAW;
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(MAX_FRAME_WORDS - 1);
    localparam logic [3:0]       GAP_LAST  = 4'(IFG_WORDS - 1);

    localparam logic [63:0] IDLE_TXD = 64'h0707070707070707;
    localparam logic [63:0] ERR_TXD  = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [7:0]  CTRL_ALL = 8'hFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             last_src;
    logic [CNT_W-1:0] word_cnt;
    logic [3:0]       gap_cnt;

    logic             cur_valid;
    logic             cur_last;
    logic [63:0]      cur_txd;
    logic [7:0]       cur_txc;

    logic             grant_req;
    logic             grant_src;
    logic             word_take;
    logic             frame_done;
    logic             word_limit;
    logic             underrun;
    logic             abort_hit;

    // Handshake: a word moves when sN_valid && sN_ready in the same cycle. Ready depends
    // only on state and active_src, never on valid; valid dropping mid-frame is an underrun.
    assign s0_ready = (state == ST_XFER) && !active_src;
    assign s1_ready = (state == ST_XFER) &&  active_src;
    assign busy     = (state == ST_XFER) || (state == ST_ABORT);

    always_comb begin
        cur_valid = s0_valid;
        cur_last  = s0_last;
        cur_txd   = s0_txd;
        cur_txc   = s0_txc;
        if (active_src) begin
            cur_valid = s1_valid;
            cur_last  = s1_last;
            cur_txd   = s1_txd;
            cur_txc   = s1_txc;
        end
    end

    // With both requesting, the source that did not own the previous frame wins.
    assign grant_req = enable && (s0_valid || s1_valid);
    assign grant_src = (s0_valid && s1_valid) ? ~last_src : s1_valid;

    assign word_take  = (state == ST_XFER) && cur_valid;
    assign frame_done = word_take && cur_last;
    assign word_limit = (word_cnt == LIMIT_CNT);
    assign underrun   = (state == ST_XFER) && !cur_valid;
    assign abort_hit  = underrun || (state == ST_ABORT);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_req) begin
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!cur_valid || cur_last) begin
                    state_nxt = ST_GAP;
                end else if (word_limit) begin
                    state_nxt = ST_ABORT;
                end
            end
            ST_ABORT: state_nxt = ST_GAP;
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            active_src <= 1'b0;
            last_src   <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && grant_req) begin
                active_src <= grant_src;
                last_src   <= grant_src;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            word_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if (state == ST_IDLE) begin
                word_cnt <= '0;
            end else if (word_take) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + 4'd1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    // Output column is always registered; anything but a forwarded word or an abort is idle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            xgmii_txd <= IDLE_TXD;
            xgmii_txc <= CTRL_ALL;
        end else if (word_take) begin
            xgmii_txd <= cur_txd;
            xgmii_txc <= cur_txc;
        end else if (abort_hit) begin
            xgmii_txd <= ERR_TXD;
            xgmii_txc <= CTRL_ALL;
        end else begin
            xgmii_txd <= IDLE_TXD;
            xgmii_txc <= CTRL_ALL;
        end
    end

    // frame_done and abort_hit are mutually exclusive, so at most one counter moves per cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            frames0   <= '0;
            frames1   <= '0;
            abort_cnt <= '0;
        end else begin
            if (frame_done && !active_src) begin
                frames0 <= frames0 + 32'd1;
            end
            if (frame_done && active_src) begin
                frames1 <= frames1 + 32'd1;
            end
            if (abort_hit && abort_cnt != 16'hFFFF) begin
                abort_cnt <= abort_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
// Bench for xgmii_tx_arbiter: frame-level reference model scheduling expected columns,
// handshakes and counters per cycle, plus directed scenarios with literal expectations.
module tb_xgmii_tx_arbiter;

    localparam int IFG  = 2;
    localparam int MAXW = 4;
    localparam logic [71:0] IDLE_COL = {64'h0707070707070707, 8'hFF};
    localparam logic [71:0] ERR_COL  = {64'hFEFEFEFEFEFEFEFE, 8'hFF};

    typedef struct {
        int          len;
        bit          has_last;
        int          under_at;
        int          pre_gap;
        logic [31:0] seed;
    } frame_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        enable = 1'b0;
    logic        s0_valid = 1'b0;
    logic [63:0] s0_txd = '0;
    logic [7:0]  s0_txc = '0;
    logic        s0_last = 1'b0;
    logic        s0_ready;
    logic        s1_valid = 1'b0;
    logic [63:0] s1_txd = '0;
    logic [7:0]  s1_txc = '0;
    logic        s1_last = 1'b0;
    logic        s1_ready;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        active_src;
    logic        busy;
    logic [31:0] frames0;
    logic [31:0] frames1;
    logic [15:0] abort_cnt;

    // clock / reset block
    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    xgmii_tx_arbiter #(.IFG_WORDS(IFG), .MAX_FRAME_WORDS(MAXW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
        .s0_valid(s0_valid), .s0_txd(s0_txd), .s0_txc(s0_txc), .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_txd(s1_txd), .s1_txc(s1_txc), .s1_last(s1_last), .s1_ready(s1_ready),
        .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc), .active_src(active_src), .busy(busy),
        .frames0(frames0), .frames1(frames1), .abort_cnt(abort_cnt)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // scoreboard: expected column / counter event per cycle, front = current cycle
    logic [71:0] exp_q[$];
    int          ev_q[$];
    int          free_at = 0;
    int          xf_lo = 1;
    int          xf_hi = 0;
    int          bz_hi = 0;
    int          xf_src = 0;
    int          m_last = 1;
    logic [31:0] m_fr0 = '0;
    logic [31:0] m_fr1 = '0;
    logic [15:0] m_ab = '0;

    frame_t drv_q0[$];
    frame_t drv_q1[$];
    frame_t mdl_q0[$];
    frame_t mdl_q1[$];
    frame_t dr_d[2];
    int     dr_idx[2];
    int     dr_gap[2];
    bit     dr_have[2];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [71:0] word_of(input frame_t d, input int k);
        return {d.seed, 32'(k), d.seed[7:0] ^ 8'(k)};
    endfunction

    function automatic frame_t mk(input int len, input bit last, input int under, input int gap);
        frame_t d;
        d.len = len;
        d.has_last = last;
        d.under_at = under;
        d.pre_gap = gap;
        d.seed = $urandom();
        return d;
    endfunction

    function automatic frame_t rand_frame();
        frame_t d;
        int kind;
        kind = $urandom_range(9, 0);
        if (kind < 6) begin
            d = mk($urandom_range(MAXW, 1), 1'b1, 0, $urandom_range(3, 0));
        end else if (kind < 8) begin
            d = mk($urandom_range(MAXW, 2), 1'b1, 0, $urandom_range(3, 0));
            d.under_at = $urandom_range(d.len - 1, 1);
        end else begin
            d = mk($urandom_range(MAXW + 3, MAXW + 1), 1'b0, 0, $urandom_range(3, 0));
        end
        return d;
    endfunction

    task automatic push(input int s, input frame_t d);
        if (s == 0) begin
            drv_q0.push_back(d);
            mdl_q0.push_back(d);
        end else begin
            drv_q1.push_back(d);
            mdl_q1.push_back(d);
        end
    endtask

    task automatic sched_col(input int at, input logic [71:0] v);
        int idx;
        idx = at - (cyc + 1);
        while (exp_q.size() <= idx) exp_q.push_back(IDLE_COL);
        exp_q[idx] = v;
    endtask

    task automatic sched_ev(input int at, input int kind);
        int idx;
        idx = at - (cyc + 1);
        while (ev_q.size() <= idx) ev_q.push_back(-1);
        ev_q[idx] = kind;
    endtask

    // Reference model: on a grant, lay out the whole frame's outcome on the timeline.
    task automatic model_step();
        frame_t d;
        int s;
        int g;
        int n;
        if (cyc < free_at || !enable || !(s0_valid || s1_valid)) return;
        s = (s0_valid && s1_valid) ? (1 - m_last) : (s1_valid ? 1 : 0);
        m_last = s;
        if ((s == 0 && mdl_q0.size() == 0) || (s == 1 && mdl_q1.size() == 0)) begin
            check("model_queue", 72'(0), 72'(1));
            return;
        end
        d = (s == 0) ? mdl_q0.pop_front() : mdl_q1.pop_front();
        g = cyc;
        xf_src = s;
        xf_lo = g + 1;
        if (d.under_at > 0) begin
            n = d.under_at;
            for (int k = 0; k < n; k++) sched_col(g + 2 + k, word_of(d, k));
            sched_col(g + n + 2, ERR_COL);
            sched_ev(g + n + 2, 2);
            xf_hi = g + n + 1;
            bz_hi = xf_hi;
            free_at = g + n + 2 + IFG;
        end else if (d.has_last && d.len <= MAXW) begin
            n = d.len;
            for (int k = 0; k < n; k++) sched_col(g + 2 + k, word_of(d, k));
            sched_ev(g + n + 1, s);
            xf_hi = g + n;
            bz_hi = xf_hi;
            free_at = g + n + 1 + IFG;
        end else begin
            for (int k = 0; k < MAXW; k++) sched_col(g + 2 + k, word_of(d, k));
            sched_col(g + MAXW + 2, ERR_COL);
            sched_ev(g + MAXW + 2, 2);
            xf_hi = g + MAXW;
            bz_hi = g + MAXW + 1;
            free_at = g + MAXW + 2 + IFG;
        end
    endtask

    task automatic compare();
        logic [71:0] col;
        int ev;
        bit in_xfer;
        bit in_busy;
        col = IDLE_COL;
        ev = -1;
        if (exp_q.size() > 0) col = exp_q.pop_front();
        if (ev_q.size() > 0) ev = ev_q.pop_front();
        case (ev)
            0: m_fr0 = m_fr0 + 32'd1;
            1: m_fr1 = m_fr1 + 32'd1;
            2: if (m_ab != 16'hFFFF) m_ab = m_ab + 16'd1;
            default: ;
        endcase
        in_xfer = (cyc >= xf_lo) && (cyc <= xf_hi);
        in_busy = (cyc >= xf_lo) && (cyc <= bz_hi);
        check("xgmii", {xgmii_txd, xgmii_txc}, col);
        check("s0_ready", 72'(s0_ready), 72'(in_xfer && xf_src == 0));
        check("s1_ready", 72'(s1_ready), 72'(in_xfer && xf_src == 1));
        check("busy", 72'(busy), 72'(in_busy));
        if (in_busy) check("active_src", 72'(active_src), 72'(xf_src));
        check("frames0", 72'(frames0), 72'(m_fr0));
        check("frames1", 72'(frames1), 72'(m_fr1));
        check("abort_cnt", 72'(abort_cnt), 72'(m_ab));
    endtask

    // driver tasks
    task automatic update_src(input int s, input bit acc);
        int cool;
        cool = 0;
        if (acc) begin
            dr_idx[s]++;
            if (dr_d[s].under_at > 0 && dr_idx[s] == dr_d[s].under_at) begin
                dr_have[s] = 1'b0;
                cool = 1;
            end else if (dr_d[s].has_last && dr_idx[s] == dr_d[s].len) begin
                dr_have[s] = 1'b0;
            end else if (dr_idx[s] == MAXW) begin
                dr_have[s] = 1'b0;
            end
        end
        if (!dr_have[s]) begin
            if (s == 0 && drv_q0.size() > 0) begin
                dr_d[0] = drv_q0.pop_front();
                dr_have[0] = 1'b1;
            end else if (s == 1 && drv_q1.size() > 0) begin
                dr_d[1] = drv_q1.pop_front();
                dr_have[1] = 1'b1;
            end
            if (dr_have[s]) begin
                dr_idx[s] = 0;
                dr_gap[s] = dr_d[s].pre_gap + cool;
            end
        end else if (dr_gap[s] > 0) begin
            dr_gap[s]--;
        end
    endtask

    task automatic apply_inputs();
        logic [71:0] w0;
        logic [71:0] w1;
        w0 = word_of(dr_d[0], dr_idx[0]);
        w1 = word_of(dr_d[1], dr_idx[1]);
        s0_valid = dr_have[0] && dr_gap[0] == 0;
        s0_txd = w0[71:8];
        s0_txc = w0[7:0];
        s0_last = dr_have[0] && dr_d[0].has_last && dr_idx[0] == dr_d[0].len - 1;
        s1_valid = dr_have[1] && dr_gap[1] == 0;
        s1_txd = w1[71:8];
        s1_txc = w1[7:0];
        s1_last = dr_have[1] && dr_d[1].has_last && dr_idx[1] == dr_d[1].len - 1;
    endtask

    task automatic step();
        bit a0;
        bit a1;
        @(negedge sys_clk);
        compare();
        model_step();
        a0 = s0_ready && s0_valid;
        a1 = s1_ready && s1_valid;
        @(posedge sys_clk);
        #1;
        cyc++;
        update_src(0, a0);
        update_src(1, a1);
        apply_inputs();
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        enable = 1'b0;
        drv_q0.delete();
        drv_q1.delete();
        mdl_q0.delete();
        mdl_q1.delete();
        exp_q.delete();
        ev_q.delete();
        for (int s = 0; s < 2; s++) begin
            dr_have[s] = 1'b0;
            dr_idx[s] = 0;
            dr_gap[s] = 0;
        end
        apply_inputs();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        cyc = 0;
        free_at = 0;
        xf_lo = 1;
        xf_hi = 0;
        bz_hi = 0;
        m_last = 1;
        m_fr0 = '0;
        m_fr1 = '0;
        m_ab = '0;
    endtask

    function automatic bit drained();
        return drv_q0.size() == 0 && drv_q1.size() == 0 && mdl_q0.size() == 0 &&
               mdl_q1.size() == 0 && !dr_have[0] && !dr_have[1] && cyc > free_at;
    endfunction

    task automatic run_drain(input string name, input bit rnd_en);
        for (int i = 0; i < 3000 && !drained(); i++) begin
            if (rnd_en) enable = ($urandom_range(7, 0) != 0);
            step();
        end
        check(name, 72'(drained()), 72'(1));
    endtask

    initial begin
        do_reset();
        // reset state
        check("rst_col", {xgmii_txd, xgmii_txc}, IDLE_COL);
        check("rst_ready", 72'({s0_ready, s1_ready}), 72'(0));
        check("rst_busy", 72'(busy), 72'(0));
        check("rst_active", 72'(active_src), 72'(0));
        check("rst_cnt", 72'({frames0, frames1, abort_cnt}), 72'(0));
        repeat (4) step();

        // single src0 frame of 3 words
        push(0, mk(3, 1'b1, 0, 0));
        enable = 1'b1;
        run_drain("t2_drain", 1'b0);
        check("t2_frames0", 72'(frames0), 72'(1));
        check("t2_frames1", 72'(frames1), 72'(0));

        // both sources back-to-back, 2-word frames
        do_reset();
        for (int i = 0; i < 2; i++) begin
            push(0, mk(2, 1'b1, 0, 0));
            push(1, mk(2, 1'b1, 0, 0));
        end
        enable = 1'b1;
        run_drain("t3_drain", 1'b0);
        check("t3_frames0", 72'(frames0), 72'(2));
        check("t3_frames1", 72'(frames1), 72'(2));
        check("t3_abort", 72'(abort_cnt), 72'(0));

        // src1 underrun on word 2 of 4, src0 waiting afterwards
        do_reset();
        push(1, mk(4, 1'b1, 1, 0));
        push(1, mk(2, 1'b1, 0, 0));
        push(0, mk(2, 1'b1, 0, 3));
        enable = 1'b1;
        run_drain("t4_drain", 1'b0);
        check("t4_abort", 72'(abort_cnt), 72'(1));
        check("t4_frames0", 72'(frames0), 72'(1));
        check("t4_frames1", 72'(frames1), 72'(1));

        // watchdog: 6 words without last, limit 4
        do_reset();
        push(0, mk(6, 1'b0, 0, 0));
        enable = 1'b1;
        run_drain("t5_drain", 1'b0);
        check("t5_abort", 72'(abort_cnt), 72'(1));
        check("t5_frames0", 72'(frames0), 72'(0));

        // reset mid-frame, then hold enable low
        do_reset();
        push(0, mk(4, 1'b1, 0, 0));
        enable = 1'b1;
        for (int i = 0; i < 20 && !(dr_have[0] && dr_idx[0] == 1); i++) step();
        check("t6_reach", 72'(dr_have[0] && dr_idx[0] == 1), 72'(1));
        sys_rst = 1'b1;
        #1;
        check("t6_col", {xgmii_txd, xgmii_txc}, IDLE_COL);
        check("t6_busy", 72'(busy), 72'(0));
        check("t6_cnt", 72'({frames0, abort_cnt}), 72'(0));
        do_reset();
        push(0, mk(2, 1'b1, 0, 0));
        repeat (10) step();
        check("t6_hold_valid", 72'(s0_valid), 72'(1));
        check("t6_hold_ready", 72'({s0_ready, busy}), 72'(0));
        enable = 1'b1;
        run_drain("t6_drain", 1'b0);
        check("t6_frames0", 72'(frames0), 72'(1));

        // randomized traffic with enable toggling
        do_reset();
        for (int i = 0; i < 60; i++) push($urandom_range(1, 0), rand_frame());
        enable = 1'b1;
        run_drain("t7_drain", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
